// File: rtl/sram_rgb_frame_reader_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | frame_reader_pkg: shared types for sram_rgb_frame_reader.  Rev 1.0       |
// +--------------------------------------------------------------------------+
package frame_reader_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_type;

   // One FIFO entry: the R, G and B words of a pixel pair ([15:8] even, [7:0] odd).
   typedef struct packed {
      logic [15:0] r;
      logic [15:0] g;
      logic [15:0] b;
   } rgb_group_t;

   localparam int WORDS_PER_GROUP = 3;

endpackage
`default_nettype wire

// File: rtl/sram_rgb_frame_reader_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sram_rgb_frame_reader_if: SRAM read port, pixel port and frame control.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface sram_rgb_frame_reader_if #(
   parameter int ADDR_W = 18
);
   logic              Frame_start;
   logic [ADDR_W-1:0] Frame_base;
   logic [ADDR_W-1:0] SRAM_address;
   logic [15:0]       SRAM_read_data;
   logic              Pixel_req;
   logic              Pixel_valid;
   logic [7:0]        Pixel_R;
   logic [7:0]        Pixel_G;
   logic [7:0]        Pixel_B;
   logic              Underflow;
   logic              Frame_done;

   modport master (
      input  Frame_start, Frame_base, SRAM_read_data, Pixel_req,
      output SRAM_address, Pixel_valid, Pixel_R, Pixel_G, Pixel_B, Underflow, Frame_done
   );

   modport slave (
      output Frame_start, Frame_base, SRAM_read_data, Pixel_req,
      input  SRAM_address, Pixel_valid, Pixel_R, Pixel_G, Pixel_B, Underflow, Frame_done
   );
endinterface
`default_nettype wire

// File: rtl/sram_rgb_frame_reader_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rgb_group_fifo: synchronous FIFO of pixel-pair groups; flush wins.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rgb_group_fifo
   import frame_reader_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   push,
   input  rgb_group_t             din,
   input  logic                   pop,
   output rgb_group_t             dout,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   rgb_group_t       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: rtl/sram_rgb_frame_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sram_rgb_frame_reader: SRAM RGB frame -> group FIFO -> VGA pixel stream. |
// | Optional LINE_DOUBLE_EN: 2x scaling (pixel and line repeat).  Rev 1.0    |
// +--------------------------------------------------------------------------+
module sram_rgb_frame_reader
   import frame_reader_pkg::*;
#(
   parameter int H_PIXELS     = 320,
   parameter int V_LINES      = 240,
   parameter int ADDR_W       = 18,
   parameter int SRAM_LATENCY = 2,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic Clock_50,
   input  logic Reset,
   sram_rgb_frame_reader_if.master bus
);
   localparam int LINE_WORDS = WORDS_PER_GROUP * (H_PIXELS / 2);
   localparam int LW_W       = $clog2(LINE_WORDS + 1);
   localparam int LN_W       = $clog2(V_LINES + 1);
   localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
   localparam int IF_W       = $clog2(SRAM_LATENCY + 1);
   localparam int CRD_W      = $clog2(WORDS_PER_GROUP * FIFO_DEPTH + SRAM_LATENCY + 3) + 1;
`ifdef LINE_DOUBLE_EN
   localparam logic [1:0] PHASE_STEP = 2'd1;
`else
   localparam logic [1:0] PHASE_STEP = 2'd2;
`endif

   state_type               state;
   logic [ADDR_W-1:0]       address;
   logic [LW_W-1:0]         word_in_line;
   logic [LN_W-1:0]         line_cnt;
   logic [SRAM_LATENCY-1:0] tag_sr;
   logic [IF_W-1:0]         inflight;
   logic [1:0]              asm_words;
   logic [15:0]             asm_r;
   logic [15:0]             asm_g;
   logic                    frame_done;
`ifdef LINE_DOUBLE_EN
   logic [ADDR_W-1:0]       line_base;
   logic                    second_pass;
`endif

   logic                    pix_valid;
   logic [7:0]              pix_r;
   logic [7:0]              pix_g;
   logic [7:0]              pix_b;
   logic                    underflow;
   logic [1:0]              phase;

   logic [CNT_W-1:0]        fifo_count;
   logic                    fifo_empty;
   rgb_group_t              head_group;
   rgb_group_t              push_group;
   logic                    push;
   logic                    pop;
   logic                    issue;
   logic                    ret;
   logic                    last_word_of_line;
   logic                    last_line;
   logic                    last_issue;
   logic                    pixel_avail;
   logic                    odd_half;
   logic [1:0]              phase_next;
   logic [CRD_W-1:0]        credit_used;
   logic [CRD_W-1:0]        credit_free;

   // Words already requested or half-assembled must still fit in free FIFO slots.
   assign credit_used = CRD_W'(inflight) + CRD_W'(asm_words);
   assign credit_free = CRD_W'(WORDS_PER_GROUP) * (CRD_W'(FIFO_DEPTH) - CRD_W'(fifo_count));
   assign issue       = (state == S_FETCH) && (credit_used < credit_free);
   assign ret         = tag_sr[SRAM_LATENCY-1];
   assign push        = ret && (asm_words == 2'd2);
   assign push_group  = {asm_r, asm_g, bus.SRAM_read_data};

   assign last_word_of_line = (word_in_line == LW_W'(LINE_WORDS - 1));
   assign last_line         = (line_cnt == LN_W'(V_LINES - 1));
`ifdef LINE_DOUBLE_EN
   assign last_issue = issue && last_word_of_line && last_line && second_pass;
`else
   assign last_issue = issue && last_word_of_line && last_line;
`endif

   assign pixel_avail = !fifo_empty && ((state == S_FETCH) || (state == S_DRAIN));
   assign odd_half    = phase[1];
   assign phase_next  = phase + PHASE_STEP;
   assign pop         = bus.Pixel_req && pixel_avail && (phase_next == 2'd0);

   rgb_group_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (Clock_50),
      .rst   (Reset),
      .flush (bus.Frame_start),
      .push  (push),
      .din   (push_group),
      .pop   (pop),
      .dout  (head_group),
      .count (fifo_count),
      .empty (fifo_empty)
   );

   always_ff @(posedge Clock_50 or posedge Reset) begin
      if (Reset) begin
         state        <= S_IDLE;
         address      <= '0;
         word_in_line <= '0;
         line_cnt     <= '0;
         tag_sr       <= '0;
         inflight     <= '0;
         asm_words    <= '0;
         asm_r        <= '0;
         asm_g        <= '0;
         frame_done   <= 1'b0;
`ifdef LINE_DOUBLE_EN
         line_base    <= '0;
         second_pass  <= 1'b0;
`endif
      end else if (bus.Frame_start) begin
         state        <= S_FETCH;
         address      <= bus.Frame_base;
         word_in_line <= '0;
         line_cnt     <= '0;
         tag_sr       <= '0;
         inflight     <= '0;
         asm_words    <= '0;
         frame_done   <= 1'b0;
`ifdef LINE_DOUBLE_EN
         line_base    <= bus.Frame_base;
         second_pass  <= 1'b0;
`endif
      end else begin
         tag_sr   <= (tag_sr << 1) | SRAM_LATENCY'(issue);
         inflight <= inflight + IF_W'(issue) - IF_W'(ret);

         if (ret) begin
            case (asm_words)
               2'd0:    asm_r <= bus.SRAM_read_data;
               2'd1:    asm_g <= bus.SRAM_read_data;
               default: ;
            endcase
            asm_words <= (asm_words == 2'd2) ? 2'd0 : asm_words + 2'd1;
         end

         if (issue) begin
`ifdef LINE_DOUBLE_EN
            if (last_word_of_line) begin
               word_in_line <= '0;
               if (!second_pass) begin
                  address     <= line_base;
                  second_pass <= 1'b1;
               end else begin
                  address     <= address + ADDR_W'(1);
                  line_base   <= address + ADDR_W'(1);
                  second_pass <= 1'b0;
                  line_cnt    <= line_cnt + LN_W'(1);
               end
            end else begin
               word_in_line <= word_in_line + LW_W'(1);
               address      <= address + ADDR_W'(1);
            end
`else
            if (last_word_of_line) begin
               word_in_line <= '0;
               line_cnt     <= line_cnt + LN_W'(1);
            end else begin
               word_in_line <= word_in_line + LW_W'(1);
            end
            address <= address + ADDR_W'(1);
`endif
         end

         case (state)
            S_FETCH: if (last_issue) state <= S_DRAIN;
            S_DRAIN: begin
               if ((inflight == '0) && fifo_empty) begin
                  state      <= S_DONE;
                  frame_done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge Clock_50 or posedge Reset) begin
      if (Reset) begin
         pix_valid <= 1'b0;
         pix_r     <= '0;
         pix_g     <= '0;
         pix_b     <= '0;
         underflow <= 1'b0;
         phase     <= '0;
      end else if (bus.Frame_start) begin
         pix_valid <= 1'b0;
         underflow <= 1'b0;
         phase     <= '0;
      end else begin
         pix_valid <= 1'b0;
         if (bus.Pixel_req) begin
            if (pixel_avail) begin
               pix_valid <= 1'b1;
               pix_r     <= odd_half ? head_group.r[7:0] : head_group.r[15:8];
               pix_g     <= odd_half ? head_group.g[7:0] : head_group.g[15:8];
               pix_b     <= odd_half ? head_group.b[7:0] : head_group.b[15:8];
               phase     <= phase_next;
            end else begin
               pix_r     <= '0;
               pix_g     <= '0;
               pix_b     <= '0;
               underflow <= 1'b1;
            end
         end
      end
   end

   assign bus.SRAM_address = address;
   assign bus.Pixel_valid  = pix_valid;
   assign bus.Pixel_R      = pix_r;
   assign bus.Pixel_G      = pix_g;
   assign bus.Pixel_B      = pix_b;
   assign bus.Underflow    = underflow;
   assign bus.Frame_done   = frame_done;
endmodule
`default_nettype wire

// File: tb/tb_sram_rgb_frame_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sram_rgb_frame_reader: two readers (SRAM latency 2 and 3) on shared   |
// | random stimulus, checked against a frame-level pixel model.  Rev 1.0     |
// +--------------------------------------------------------------------------+
module tb_sram_rgb_frame_reader;
   import frame_reader_pkg::*;

   localparam int ADDR_W = 18;
   localparam int V      = 2;
   localparam int DEPTH  = 8;
`ifdef LINE_DOUBLE_EN
   localparam int H   = 4;
   localparam int REP = 2;
`else
   localparam int H   = 8;
   localparam int REP = 1;
`endif
   localparam int FRAME_WORDS = 3 * H / 2 * V;
   localparam int NPIX        = H * V * REP * REP;
   localparam int NINST       = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              frame_start;
   logic [ADDR_W-1:0] frame_base;
   logic              pixel_req;

   logic [NINST-1:0][ADDR_W-1:0] mon_addr;
   logic [NINST-1:0][23:0]       mon_rgb;
   logic [NINST-1:0]             mon_valid;
   logic [NINST-1:0]             mon_under;
   logic [NINST-1:0]             mon_done;
   int                           pix_cnt [NINST];
   logic [23:0]                  exp_pix [NPIX];
   int                           n_cmp = 0;
   int                           n_bad = 0;

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   function automatic logic [15:0] sram_word(input logic [ADDR_W-1:0] a);
      return {a[7:0], a[7:0] | 8'h80};
   endfunction

   function automatic logic [7:0] plane_byte(input logic [ADDR_W-1:0] a, input bit odd);
      logic [15:0] w;
      w = sram_word(a);
      return odd ? w[7:0] : w[15:8];
   endfunction

   // Whole-frame output order: per line, REP passes; per pixel, REP repeats.
   task automatic build_expect(input logic [ADDR_W-1:0] base);
      int n;
      logic [ADDR_W-1:0] a;
      bit odd;
      n = 0;
      for (int y = 0; y < V; y++)
         for (int pass = 0; pass < REP; pass++)
            for (int x = 0; x < H; x++)
               for (int r = 0; r < REP; r++) begin
                  a   = base + ADDR_W'(3 * (y * H / 2 + x / 2));
                  odd = (x % 2) == 1;
                  exp_pix[n] = {plane_byte(a, odd), plane_byte(a + ADDR_W'(1), odd),
                                plane_byte(a + ADDR_W'(2), odd)};
                  n++;
               end
   endtask

   for (genvar i = 0; i < NINST; i++) begin : g_inst
      localparam int LAT = 2 + i;
      logic [15:0] pipe [LAT];

      sram_rgb_frame_reader_if #(.ADDR_W(ADDR_W)) bus ();

      assign bus.Frame_start    = frame_start;
      assign bus.Frame_base     = frame_base;
      assign bus.Pixel_req      = pixel_req;
      assign bus.SRAM_read_data = pipe[LAT-1];

      always @(posedge clk) begin
         pipe[0] <= sram_word(bus.SRAM_address);
         for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
      end

      sram_rgb_frame_reader #(
         .H_PIXELS     (H),
         .V_LINES      (V),
         .ADDR_W       (ADDR_W),
         .SRAM_LATENCY (LAT),
         .FIFO_DEPTH   (DEPTH)
      ) u_dut (
         .Clock_50 (clk),
         .Reset    (rst),
         .bus      (bus)
      );

      assign mon_addr[i]  = bus.SRAM_address;
      assign mon_rgb[i]   = {bus.Pixel_R, bus.Pixel_G, bus.Pixel_B};
      assign mon_valid[i] = bus.Pixel_valid;
      assign mon_under[i] = bus.Underflow;
      assign mon_done[i]  = bus.Frame_done;

      always @(negedge clk) begin
         if (frame_start) begin
            pix_cnt[i] <= 0;
         end else if (bus.Pixel_valid) begin
            if (pix_cnt[i] < NPIX)
               check($sformatf("pixel[%0d] lat%0d", pix_cnt[i], LAT),
                     32'(mon_rgb[i]), 32'(exp_pix[pix_cnt[i]]));
            else
               check($sformatf("extra_pixel lat%0d", LAT), 32'(mon_rgb[i]), 32'hFFFF_FFFF);
            pix_cnt[i] <= pix_cnt[i] + 1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame(input logic [ADDR_W-1:0] base);
      pixel_req = 1'b0;
      step();
      build_expect(base);
      frame_base  = base;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int cyc;
      cyc = 0;
      while (mon_done != '1 && cyc < 100) begin
         step();
         cyc++;
      end
      @(negedge clk);
      for (int i = 0; i < NINST; i++) begin
         check($sformatf("%s_done%0d", name, i), 32'(mon_done[i]), 32'd1);
         check($sformatf("%s_count%0d", name, i), 32'(pix_cnt[i]), 32'(NPIX));
      end
      step();
   endtask

   task automatic run_random(input string name, input int density, input int prefill);
      int cyc;
      repeat (prefill) step();
      cyc = 0;
      while ((pix_cnt[0] < NPIX || pix_cnt[1] < NPIX) && cyc < 5000) begin
         pixel_req = ($urandom_range(99) < density);
         step();
         cyc++;
      end
      pixel_req = 1'b0;
      check({name, "_timeout"}, 32'(cyc < 5000), 32'd1);
      wait_done(name);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cyc;
      rst         = 1'b1;
      frame_start = 1'b0;
      frame_base  = '0;
      pixel_req   = 1'b0;

      // Reset held with random inputs: all outputs stay at zero.
      for (int c = 0; c < 6; c++) begin
         step();
         frame_start = 1'($urandom_range(1));
         pixel_req   = 1'($urandom_range(1));
         frame_base  = ADDR_W'($urandom);
         @(negedge clk);
         for (int i = 0; i < NINST; i++) begin
            check($sformatf("reset_addr%0d", i), 32'(mon_addr[i]), 32'd0);
            check($sformatf("reset_outs%0d", i),
                  32'({mon_valid[i], mon_under[i], mon_done[i], mon_rgb[i]}), 32'd0);
         end
      end
      frame_start = 1'b0;
      pixel_req   = 1'b0;
      step();
      rst = 1'b0;
      step();
      check("idle_state", 32'(g_inst[0].u_dut.state), 32'(S_IDLE));

      // A request while idle is an underflow.
      pixel_req = 1'b1;
      step();
      pixel_req = 1'b0;
      @(negedge clk);
      check("idle_req_valid", 32'(mon_valid), 32'd0);
      check("idle_req_under", 32'(mon_under), 32'(2'b11));

      // Request one cycle after Frame_start finds the FIFO empty.
      start_frame('0);
      pixel_req = 1'b1;
      step();
      pixel_req = 1'b0;
      @(negedge clk);
      check("early_req_valid", 32'(mon_valid), 32'd0);
      check("early_req_rgb0", 32'(mon_rgb[0]), 32'd0);
      check("early_req_under", 32'(mon_under), 32'(2'b11));
      start_frame('0);
      @(negedge clk);
      check("restart_clears_under", 32'(mon_under), 32'd0);

      // Steady consumer, one request every other cycle after prefill.
      repeat (40) step();
      cyc = 0;
      while ((pix_cnt[0] < NPIX || pix_cnt[1] < NPIX) && cyc < 2000) begin
         pixel_req = 1'b1;
         step();
         pixel_req = 1'b0;
         step();
         cyc++;
      end
      check("steady_timeout", 32'(cyc < 2000), 32'd1);
      wait_done("steady");
      check("steady_no_underflow", 32'(mon_under), 32'd0);

      // No consumer: fetch stops once the FIFO credit is used up.
      start_frame('0);
      repeat (100) step();
      @(negedge clk);
      for (int i = 0; i < NINST; i++) begin
         check($sformatf("stall_addr%0d", i), 32'(mon_addr[i]), 32'(FRAME_WORDS));
         check($sformatf("stall_done%0d", i), 32'(mon_done[i]), 32'd0);
         check($sformatf("stall_count%0d", i), 32'(pix_cnt[i]), 32'd0);
      end
      step();

      // Mid-frame restart at a new base: only new-frame pixels may appear.
      start_frame('0);
      repeat (30) step();
      for (int c = 0; c < 12; c++) begin
         pixel_req = 1'($urandom_range(1));
         step();
      end
      start_frame(18'h10000);
      run_random("restart", 60, 30);

      // Random bases (one wrapping the address space) and consumer densities.
      start_frame(18'h3FFF8);
      run_random("wrap", 50, $urandom_range(40));
      for (int r = 0; r < 3; r++) begin
         start_frame(ADDR_W'($urandom));
         run_random($sformatf("rand%0d", r), 20 + $urandom_range(70), $urandom_range(40));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
